// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding and parameter defaults for the hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } hz_state_e;

  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int FLUSH_DEPTH_DEF = 1;

endpackage

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - saturating 16-bit stall and flush event counters
module hazard_perf_cnt
  import hazard_pkg::*;
(
  input  logic        clock,
  input  logic        nreset,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
);

  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_inc && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;

endmodule

// File: rtl/hazard_ctl.sv
// rtl/hazard_ctl.sv - pipeline hazard controller: load-use bubbles, MEM waits with timeout, branch flush.
// Optional perf counters enabled by macro HAZARD_PERF_CNT_EN.
module hazard_ctl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [4:0]  id_rs_top,
  input  logic        id_rs_top_valid,
  input  logic [4:0]  id_rs_bot,
  input  logic        id_rs_bot_valid,
  input  logic [4:0]  ex_dest_reg,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        front_hold,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_hold,
  output logic        ex_mem_hold,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
);

  hz_state_e  state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic       load_use;
  logic       mem_busy;

  assign load_use = ex_is_load &&
                    ((id_rs_top_valid && id_rs_top == ex_dest_reg) ||
                     (id_rs_bot_valid && id_rs_bot == ex_dest_reg));
  assign mem_busy = mem_req && !mem_ready;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    front_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_hold  = 1'b0;
    ex_mem_hold = 1'b0;
    mem_timeout = 1'b0;
    // Outputs are gated by reset too, so combinational terms read 0 during reset.
    if (nreset) begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_busy) begin
            front_hold  = 1'b1;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
            wait_cnt_d  = 8'd0;
            state_d     = ST_MEM_WAIT;
          end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_stall = 1'b1;
            flush_cnt_d = 2'(FLUSH_DEPTH);
            state_d     = ST_FLUSH;
          end else if (load_use) begin
            front_hold  = 1'b1;
            id_ex_stall = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          front_hold  = 1'b1;
          id_ex_hold  = 1'b1;
          ex_mem_hold = 1'b1;
          wait_cnt_d  = wait_cnt_q + 8'd1;
          if (mem_ready) begin
            state_d = ST_RUN;
          end else if (wait_cnt_q == 8'(MEM_TIMEOUT - 1)) begin
            mem_timeout = 1'b1;
            state_d     = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if_id_flush = 1'b1;
          flush_cnt_d = flush_cnt_q - 2'd1;
          if (flush_cnt_q == 2'd1) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      flush_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // flush and stall together only occur on the RUN-to-FLUSH cycle.
  logic flush_evt;
  assign flush_evt = if_id_flush && id_ex_stall;

  hazard_perf_cnt u_perf_cnt (
    .clock        (clock),
    .nreset       (nreset),
    .stall_inc    (front_hold),
    .flush_inc    (flush_evt),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );
`else
  assign stall_cycles = 16'd0;
  assign flush_events = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// tb/tb_hazard_ctl.sv - directed self-checking bench for hazard_ctl (MEM_TIMEOUT=8, FLUSH_DEPTH=2)
module tb_hazard_ctl;

  logic        clock;
  logic        nreset;
  logic [4:0]  id_rs_top;
  logic        id_rs_top_valid;
  logic [4:0]  id_rs_bot;
  logic        id_rs_bot_valid;
  logic [4:0]  ex_dest_reg;
  logic        ex_is_load;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        front_hold;
  logic        if_id_flush;
  logic        id_ex_stall;
  logic        id_ex_hold;
  logic        ex_mem_hold;
  logic        mem_timeout;
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;

  logic [5:0]  hv;
  int          checks;
  int          errors;

  assign hv = {front_hold, if_id_flush, id_ex_stall, id_ex_hold, ex_mem_hold, mem_timeout};

  hazard_ctl #(.MEM_TIMEOUT(8), .FLUSH_DEPTH(2)) dut (
    .clock           (clock),
    .nreset          (nreset),
    .id_rs_top       (id_rs_top),
    .id_rs_top_valid (id_rs_top_valid),
    .id_rs_bot       (id_rs_bot),
    .id_rs_bot_valid (id_rs_bot_valid),
    .ex_dest_reg     (ex_dest_reg),
    .ex_is_load      (ex_is_load),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .front_hold      (front_hold),
    .if_id_flush     (if_id_flush),
    .id_ex_stall     (id_ex_stall),
    .id_ex_hold      (id_ex_hold),
    .ex_mem_hold     (ex_mem_hold),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    id_rs_top = 5'd0; id_rs_top_valid = 1'b0;
    id_rs_bot = 5'd0; id_rs_bot_valid = 1'b0;
    ex_dest_reg = 5'd0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_load_use_bot();
    ex_is_load = 1'b1; ex_dest_reg = 5'd5; id_rs_bot = 5'd5; id_rs_bot_valid = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    clr_in();
    set_load_use_bot();
    mem_req = 1'b1;
    ex_branch_taken = 1'b1;
    #3;
    checks++;
    if (hv !== 6'b000000) begin
      errors++; $display("FAIL reset_outputs got %b want %b", hv, 6'b000000);
    end
    checks++;
    if (stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
      errors++; $display("FAIL reset_counters got %h/%h want 0000/0000", stall_cycles, flush_events);
    end
    step();
    clr_in();
    nreset = 1'b1;
    #1;
    checks++;
    if (hv !== 6'b000000) begin
      errors++; $display("FAIL reset_idle got %b want %b", hv, 6'b000000);
    end
  endtask

  task automatic test_load_use();
    set_load_use_bot();
    #1;
    checks++;
    if (hv !== 6'b101000) begin
      errors++; $display("FAIL load_use_bot got %b want %b", hv, 6'b101000);
    end
    step();
    clr_in();
    #1;
    checks++;
    if (hv !== 6'b000000) begin
      errors++; $display("FAIL load_use_one_cycle got %b want %b", hv, 6'b000000);
    end
    set_load_use_bot();
    id_rs_bot_valid = 1'b0;
    #1;
    checks++;
    if (hv !== 6'b000000) begin
      errors++; $display("FAIL load_use_bot_invalid got %b want %b", hv, 6'b000000);
    end
    clr_in();
    ex_is_load = 1'b1; ex_dest_reg = 5'd17; id_rs_top = 5'd17; id_rs_top_valid = 1'b1;
    #1;
    checks++;
    if (hv !== 6'b101000) begin
      errors++; $display("FAIL load_use_top got %b want %b", hv, 6'b101000);
    end
    id_rs_top = 5'd16;
    #1;
    checks++;
    if (hv !== 6'b000000) begin
      errors++; $display("FAIL load_use_mismatch got %b want %b", hv, 6'b000000);
    end
    id_rs_top = 5'd17; ex_is_load = 1'b0;
    #1;
    checks++;
    if (hv !== 6'b000000) begin
      errors++; $display("FAIL load_use_not_load got %b want %b", hv, 6'b000000);
    end
    step();
    clr_in();
  endtask

  task automatic test_mem_wait();
    mem_req = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (hv !== 6'b000000) begin
      errors++; $display("FAIL mem_ready_same_cycle got %b want %b", hv, 6'b000000);
    end
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) mem_ready = 1'b1;
      #1;
      checks++;
      if (hv !== 6'b100110) begin
        errors++; $display("FAIL mem_wait_c%0d got %b want %b", i, hv, 6'b100110);
      end
      step();
    end
    clr_in();
    #1;
    checks++;
    if (hv !== 6'b000000) begin
      errors++; $display("FAIL mem_wait_release got %b want %b", hv, 6'b000000);
    end
    set_load_use_bot();
    #1;
    checks++;
    if (hv !== 6'b101000) begin
      errors++; $display("FAIL mem_wait_back_in_run got %b want %b", hv, 6'b101000);
    end
    step();
    clr_in();
  endtask

  task automatic test_timeout();
    logic [5:0] exp;
    mem_req = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      exp = (i == 8) ? 6'b100111 : 6'b100110;
      #1;
      checks++;
      if (hv !== exp) begin
        errors++; $display("FAIL timeout_c%0d got %b want %b", i, hv, exp);
      end
      step();
    end
    clr_in();
    #1;
    checks++;
    if (hv !== 6'b000000) begin
      errors++; $display("FAIL timeout_release got %b want %b", hv, 6'b000000);
    end
    step();
  endtask

  task automatic test_branch_tie();
    logic [5:0] exp;
    set_load_use_bot();
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) clr_in();
      exp = (i == 0) ? 6'b011000 : (i < 3) ? 6'b010000 : 6'b000000;
      #1;
      checks++;
      if (hv !== exp) begin
        errors++; $display("FAIL branch_tie_c%0d got %b want %b", i, hv, exp);
      end
      step();
    end
    clr_in();
  endtask

  task automatic test_back_to_back();
    mem_req = 1'b1;
    ex_branch_taken = 1'b1;
    set_load_use_bot();
    #1;
    checks++;
    if (hv !== 6'b100110) begin
      errors++; $display("FAIL mem_over_branch got %b want %b", hv, 6'b100110);
    end
    step();
    mem_ready = 1'b1;
    #1;
    checks++;
    if (id_ex_hold && id_ex_stall) begin
      errors++; $display("FAIL hold_stall_exclusive got %b%b want not both", id_ex_hold, id_ex_stall);
    end
    step();
    mem_req = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if (hv !== 6'b011000) begin
      errors++; $display("FAIL branch_after_mem got %b want %b", hv, 6'b011000);
    end
    step();
    clr_in();
    step();
    step();
  endtask

  task automatic test_reset_mid_wait();
    mem_req = 1'b1;
    step();
    step();
    step();
    nreset = 1'b0;
    #1;
    checks++;
    if (hv !== 6'b000000) begin
      errors++; $display("FAIL reset_mid_wait got %b want %b", hv, 6'b000000);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (mem_timeout !== 1'b0 || hv !== 6'b000000) begin
        errors++; $display("FAIL reset_hold_c%0d got %b want %b", i, hv, 6'b000000);
      end
    end
    clr_in();
    nreset = 1'b1;
    step();
    set_load_use_bot();
    #1;
    checks++;
    if (hv !== 6'b101000) begin
      errors++; $display("FAIL reset_back_in_run got %b want %b", hv, 6'b101000);
    end
    step();
    clr_in();
  endtask

  task automatic test_perf();
    nreset = 1'b0;
    step();
    nreset = 1'b1;
    set_load_use_bot();
    step(); step(); step();
    clr_in();
    ex_branch_taken = 1'b1;
    step();
    clr_in();
    step(); step();
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 16'd3) begin
      errors++; $display("FAIL perf_stall got %0d want %0d", stall_cycles, 3);
    end
    checks++;
    if (flush_events !== 16'd1) begin
      errors++; $display("FAIL perf_flush got %0d want %0d", flush_events, 1);
    end
    mem_req = 1'b1;
    repeat (65540) step();
    clr_in();
    step();
    checks++;
    if (stall_cycles !== 16'hFFFF) begin
      errors++; $display("FAIL perf_saturate got %h want %h", stall_cycles, 16'hFFFF);
    end
    checks++;
    if (flush_events !== 16'd1) begin
      errors++; $display("FAIL perf_flush_after_sat got %0d want %0d", flush_events, 1);
    end
`else
    checks++;
    if (stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
      errors++; $display("FAIL perf_disabled got %h/%h want 0000/0000", stall_cycles, flush_events);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_branch_tie();
    test_back_to_back();
    test_reset_mid_wait();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctl.md
HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the maximum number of MEM_WAIT cycles before a forced exit (1..255).
REQ-002 SHALL have parameter FLUSH_DEPTH, default 1, the number of extra cycles if_id_flush stays asserted after a taken branch (1..3).
REQ-003 SHALL have port clock, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have port nreset, input, 1, system reset; asynchronous, active-low.
REQ-005 SHALL have port id_rs_top, input, 5, top source register index of the instruction in ID.
REQ-006 SHALL have port id_rs_top_valid, input, 1, the instruction in ID reads id_rs_top.
REQ-007 SHALL have port id_rs_bot, input, 5, bottom source register index of the instruction in ID.
REQ-008 SHALL have port id_rs_bot_valid, input, 1, the instruction in ID reads id_rs_bot.
REQ-009 SHALL have port ex_dest_reg, input, 5, destination register index of the instruction in EX.
REQ-010 SHALL have port ex_is_load, input, 1, the instruction in EX is a memory read that writes the register file.
REQ-011 SHALL have port ex_branch_taken, input, 1, a jump, call or return resolved taken in EX.
REQ-012 SHALL have port mem_req, input, 1, the instruction in MEM issues a multi-cycle access.
REQ-013 SHALL have port mem_ready, input, 1, the MEM access completes this cycle.
REQ-014 SHALL have port front_hold, output, 1, holds the PC and if_id.
REQ-015 SHALL have port if_id_flush, output, 1, zeroes if_id.
REQ-016 SHALL have port id_ex_stall, output, 1, inserts a bubble into id_ex; drives the id_ex stall input.
REQ-017 SHALL have port id_ex_hold, output, 1, freezes id_ex contents.
REQ-018 SHALL have port ex_mem_hold, output, 1, freezes ex_mem contents.
REQ-019 SHALL have port mem_timeout, output, 1, one-cycle pulse when a MEM wait is aborted.
REQ-020 SHALL have port stall_cycles, output, 16, saturating count of front_hold cycles.
REQ-021 SHALL have port flush_events, output, 16, saturating count of taken-branch flushes.

Function
REQ-022 SHALL implement FSM states RUN, MEM_WAIT and FLUSH, with a registered state, an 8-bit wait counter and a 2-bit flush counter.
REQ-023 SHALL, in RUN, assert load_use when ex_is_load=1 and (id_rs_top_valid and id_rs_top==ex_dest_reg, or id_rs_bot_valid and id_rs_bot==ex_dest_reg).
REQ-024 SHALL, in RUN, set mem_busy = mem_req and not mem_ready.
REQ-025 SHALL resolve RUN priority as mem_busy > ex_branch_taken > load_use.
REQ-026 SHALL, on mem_busy in RUN, assert front_hold, id_ex_hold and ex_mem_hold combinationally in the same cycle, clear the wait counter and go to MEM_WAIT.
REQ-027 SHALL, in MEM_WAIT, keep front_hold, id_ex_hold and ex_mem_hold asserted.
REQ-028 SHALL, in MEM_WAIT, increment the wait counter each cycle.
REQ-029 SHALL return from MEM_WAIT to RUN on mem_ready=1, with holds deasserted from the next cycle.
REQ-030 SHALL, in MEM_WAIT, pulse mem_timeout for one cycle and return to RUN when the counter reaches MEM_TIMEOUT-1 with mem_ready=0.
REQ-031 SHALL, on ex_branch_taken in RUN without mem_busy, assert if_id_flush and id_ex_stall that cycle, load the flush counter with FLUSH_DEPTH and go to FLUSH.
REQ-032 SHALL, in FLUSH, assert if_id_flush only.
REQ-033 SHALL, in FLUSH, decrement the flush counter and return to RUN when it reaches 1.
REQ-034 SHALL ignore load_use and ex_branch_taken while in FLUSH.
REQ-035 SHALL, on load_use in RUN without mem_busy or ex_branch_taken, assert front_hold and id_ex_stall for exactly that cycle, with no state change.
REQ-036 SHALL, when mem_req=1 and mem_ready=1 in the same RUN cycle, neither hold nor change state.
REQ-037 SHALL keep id_ex_hold and id_ex_stall mutually exclusive in every cycle.

Reset
REQ-038 SHALL, while nreset=0, force state=RUN, zero all counters and drive every output 0, including the combinational terms.
REQ-039 SHALL, on reset asserted mid-MEM_WAIT or mid-FLUSH, abandon the sequence without a mem_timeout pulse.

Configuration
REQ-040 SHALL, with macro HAZARD_PERF_CNT_EN defined, increment stall_cycles on each front_hold cycle and flush_events on each RUN-to-FLUSH transition, both saturating at 16'hFFFF.
REQ-041 SHALL, without HAZARD_PERF_CNT_EN, drive stall_cycles and flush_events constant 0 with no counter logic.

Structure
REQ-042 SHALL define the state encoding typedef and the MEM_TIMEOUT and FLUSH_DEPTH defaults in shared package hazard_pkg.
REQ-043 SHALL place the saturating counters in sub-module hazard_perf_cnt, instantiated only under HAZARD_PERF_CNT_EN.

Verification
REQ-044 SHALL cover load-use: ex_is_load=1, ex_dest_reg=5, id_rs_bot=5, id_rs_bot_valid=1 -> front_hold=1 and id_ex_stall=1 for 1 cycle; no bubble when id_rs_bot_valid=0.
REQ-045 SHALL cover MEM wait: mem_req=1 with mem_ready rising after 4 cycles -> the three holds stay high for 5 cycles, then state is RUN.
REQ-046 SHALL cover timeout: MEM_TIMEOUT=8, mem_ready=0 throughout -> mem_timeout pulses on the 8th wait cycle, then holds drop.
REQ-047 SHALL cover the branch-over-load-use tie: ex_branch_taken=1 together with load_use, FLUSH_DEPTH=2 -> if_id_flush high for 3 cycles, id_ex_stall for 1 cycle, front_hold=0.
REQ-048 SHALL cover reset mid-wait: nreset=0 in the 3rd MEM_WAIT cycle -> all outputs 0 immediately, no mem_timeout.
REQ-049 SHALL cover saturation: with HAZARD_PERF_CNT_EN defined, 65540 hold cycles -> stall_cycles=16'hFFFF.
